// File: rtl/vscale_arb_pkg.sv
// Shared definitions for the data-memory scheduler: HASTI encodings,
// core index width helper and the held-response entry.
package vscale_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;

  function automatic int core_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic        held;
    logic [31:0] data;
    logic        resp;
  } held_ent_t;

endpackage

// File: rtl/vscale_rr_pick.sv
// Rotate-priority picker: first requester after ptr_i, wrapping
// modulo N, wins.
module vscale_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          grant_valid_o,
  output logic [IW-1:0] grant_id_o
);

  int            s;
  logic [IW-1:0] idx;

  // Walk from the farthest slot back to the nearest so the nearest wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    s             = 0;
    idx           = '0;
    for (int k = N; k >= 1; k--) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      idx = IW'(s);
      if (req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/vscale_rr_dmem_sched.sv
// Shares one SRAM HASTI port among NUM_CORES masters.
// VSCALE_ARB_EXT_SCHED_EN selects an external next_core schedule.
module vscale_rr_dmem_sched
  import vscale_arb_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  localparam int IW        = core_idx_w(NUM_CORES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0][31:0] core_haddr,
  input  logic [NUM_CORES-1:0]       core_hwrite,
  input  logic [NUM_CORES-1:0][2:0]  core_hsize,
  input  logic [NUM_CORES-1:0][1:0]  core_htrans,
  input  logic [NUM_CORES-1:0][31:0] core_hwdata,
  output logic [NUM_CORES-1:0][31:0] core_hrdata,
  output logic [NUM_CORES-1:0]       core_hready,
  output logic [NUM_CORES-1:0]       core_hresp,
  output logic [31:0]                mem_haddr,
  output logic                       mem_hwrite,
  output logic [2:0]                 mem_hsize,
  output logic [1:0]                 mem_htrans,
  output logic [31:0]                mem_hwdata,
  input  logic [31:0]                mem_hrdata,
  input  logic                       mem_hready,
  input  logic                       mem_hresp,
`ifdef VSCALE_ARB_EXT_SCHED_EN
  input  logic [IW-1:0]              next_core,
`endif
  output logic                       grant_valid,
  output logic [IW-1:0]              grant_id
);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] gnt_oh;
  logic [NUM_CORES-1:0] own_oh;
  logic                 pick_v;
  logic [IW-1:0]        pick_id;
  logic                 gnt_v;

  logic                 dp_valid_q, dp_valid_d;
  logic [IW-1:0]        dp_owner_q, dp_owner_d;
  held_ent_t [NUM_CORES-1:0] held_q, held_d;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++)
      req[i] = (core_htrans[i] == HTRANS_NONSEQ);
  end

`ifdef VSCALE_ARB_EXT_SCHED_EN
  assign pick_v  = req[next_core];
  assign pick_id = next_core;
`else
  logic [IW-1:0] last_q, last_d;

  vscale_rr_pick #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_pick (
    .req_i         (req),
    .ptr_i         (last_q),
    .grant_valid_o (pick_v),
    .grant_id_o    (pick_id)
  );

  always_comb begin
    last_d = last_q;
    if (gnt_v) last_d = pick_id;
  end

  // Reset pointer to the last core so core 0 wins the first round.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IW'(NUM_CORES - 1);
    else       last_q <= last_d;
  end
`endif

  assign gnt_v       = pick_v & mem_hready & ~reset;
  assign grant_valid = gnt_v;
  assign grant_id    = gnt_v ? pick_id : '0;

  always_comb begin
    gnt_oh = '0;
    own_oh = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      gnt_oh[i] = gnt_v && (pick_id == IW'(i));
      own_oh[i] = dp_valid_q && (dp_owner_q == IW'(i));
    end
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    held_d     = held_q;
    if (mem_hready) begin
      dp_valid_d = gnt_v;
      if (gnt_v) dp_owner_d = pick_id;
    end
    if (gnt_v) held_d[pick_id].held = 1'b0;
    // Owner already stalled on a fresh request: park its response.
    if (dp_valid_q && mem_hready && req[dp_owner_q]
        && !gnt_oh[dp_owner_q]) begin
      held_d[dp_owner_q].held = 1'b1;
      held_d[dp_owner_q].data = mem_hrdata;
      held_d[dp_owner_q].resp = mem_hresp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_valid_q <= 1'b0;
      dp_owner_q <= '0;
      held_q     <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      held_q     <= held_d;
    end
  end

  always_comb begin
    mem_htrans = HTRANS_IDLE;
    mem_haddr  = '0;
    mem_hwrite = 1'b0;
    mem_hsize  = '0;
    if (gnt_v) begin
      mem_htrans = core_htrans[pick_id];
      mem_haddr  = core_haddr[pick_id];
      mem_hwrite = core_hwrite[pick_id];
      mem_hsize  = core_hsize[pick_id];
    end
    mem_hwdata = dp_valid_q ? core_hwdata[dp_owner_q] : '0;
  end

  always_comb begin
    core_hready = '1;
    core_hrdata = '0;
    core_hresp  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (reset) begin
        core_hready[i] = 1'b1;
        core_hrdata[i] = '0;
        core_hresp[i]  = HRESP_OKAY;
      end else if (held_q[i].held) begin
        core_hready[i] = gnt_oh[i];
        core_hrdata[i] = held_q[i].data;
        core_hresp[i]  = held_q[i].resp;
      end else begin
        if (own_oh[i])
          core_hready[i] = mem_hready & (~req[i] | gnt_oh[i]);
        else
          core_hready[i] = ~req[i] | gnt_oh[i];
        core_hrdata[i] = mem_hrdata;
        core_hresp[i]  = mem_hresp;
      end
    end
  end

endmodule
